save_restore: RTL and testbench
===============================

Name: save_restore

Overview:
- Consumer end of the save-point event path.
- Captures the kid's position when a save button reports a new trigger.
- On death plus restart key, or on restart key alone, runs a timed respawn sequence.
- Hands the restored position to the kid-movement logic over a valid/ack handshake.
- Sits between the save-button instances and the kid controller; also exports a death counter for the HUD.

Parameters:
START_X, 10'd32, spawn x used before any save exists
START_Y, 10'd400, spawn y used before any save exists
DELAY_CYCLES, 24'd1000000, cycles between respawn key accept and restore_valid assertion (minimum 1)
DEATH_MAX, 10'd999, saturation value of death_count

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
save_trig  input  1  level; high once any save button is triggered (OR of buttons' triggered flags); may stay high
kid_x  input  10  current kid x
kid_y  input  10  current kid y
death  input  1  level; high while kid is in the dead condition
respawn_key  input  1  single-cycle pulse from key decoder
restore_ack  input  1  kid controller has loaded restore_x/restore_y
restore_valid  output  1  restore position offered
restore_x  output  10  position to load
restore_y  output  10  position to load
frozen  output  1  kid input/physics disabled
has_save  output  1  a save has been captured
death_count  output  10  saturating death counter

Behaviour:
- Reset (rst=0, async):
  - state=ALIVE; save_x=START_X; save_y=START_Y; has_save=0; death_count=0; delay counter=0; restore_valid=0; frozen=0.
  - restore_x/restore_y = save_x/save_y (continuously driven).
  - Edge-detect registers cleared to 0, so save_trig or death already high when reset releases counts as a rising edge in the first active cycle.
- Edge detection: save_rise and death_rise are registered rising edges (input high this cycle, low the previous cycle).
- ALIVE:
  - frozen=0.
  - death_rise: go to DEAD; death_count += 1, saturating at DEATH_MAX.
  - Otherwise respawn_key: go to DELAY (voluntary restart); counter loads 0; death_count unchanged.
  - Otherwise save_rise: save_x<=kid_x, save_y<=kid_y, has_save<=1.
  - Priority death > respawn_key > save. A save in the same cycle as a death or key is discarded.
- DEAD:
  - frozen=1; save_rise ignored; further death edges ignored.
  - respawn_key: go to DELAY; counter loads 0.
- DELAY:
  - frozen=1; counter increments each cycle.
  - When counter == DELAY_CYCLES-1, go to RESTORE; restore_valid=1 from the next cycle.
  - respawn_key, death and save ignored.
- RESTORE:
  - frozen=1; restore_valid=1; restore_x/restore_y stable until acknowledged.
  - restore_ack=1: restore_valid drops the next cycle; go to ALIVE.
  - ack while restore_valid=0 is ignored in every state.
- Latency: key accepted at cycle T -> restore_valid first high at T+DELAY_CYCLES+1.
- A save captured while death is high cannot occur (DEAD blocks it); a save while ALIVE with death already high cannot occur because death_rise leaves ALIVE first.
- Reset mid-sequence: immediate return to ALIVE with the start position; the previous save is lost.
- The position registers are only written by save_rise in ALIVE; restore never modifies them.

Test Plan:
- Reset release, then death pulse, respawn_key, DELAY_CYCLES=4 -> restore_valid rises exactly 5 cycles after key; restore_x=32, restore_y=400; has_save=0; death_count=1.
- kid at (95,313), save_trig rises in ALIVE -> has_save=1; later death+key+ack -> restore (95,313); save_trig staying high produces no second capture at a new position.
- save_trig rise and death rise in the same cycle at kid (200,100) -> state DEAD, save unchanged (start position), death_count+1.
- restore_valid held with restore_ack low for 20 cycles -> valid and position stable, frozen=1; ack pulse -> valid low next cycle, frozen low, state ALIVE.
- respawn_key in ALIVE without death -> DELAY, then RESTORE; death_count unchanged; key pulses and death during DELAY ignored.
- 1000 death/respawn cycles with DEATH_MAX=999 -> death_count stops at 999; async reset asserted mid-DELAY -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/save_restore.sv
// Save-point consumer: captures the kid position on a new save trigger and runs
// the death/restart -> timed delay -> restore handshake back to the kid controller.
module save_restore #(
   parameter logic [9:0]  START_X      = 10'd32,
   parameter logic [9:0]  START_Y      = 10'd400,
   parameter logic [23:0] DELAY_CYCLES = 24'd1000000,
   parameter logic [9:0]  DEATH_MAX    = 10'd999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       save_trig,
   input  logic [9:0] kid_x,
   input  logic [9:0] kid_y,
   input  logic       death,
   input  logic       respawn_key,
   input  logic       restore_ack,
   output logic       restore_valid,
   output logic [9:0] restore_x,
   output logic [9:0] restore_y,
   output logic       frozen,
   output logic       has_save,
   output logic [9:0] death_count
);

   localparam logic [1:0] ST_ALIVE   = 2'd0;
   localparam logic [1:0] ST_DEAD    = 2'd1;
   localparam logic [1:0] ST_DELAY   = 2'd2;
   localparam logic [1:0] ST_RESTORE = 2'd3;

   // DELAY_CYCLES of zero would never terminate the wait; treat it as one.
   localparam logic [23:0] DELAY_LAST = (DELAY_CYCLES == 24'd0) ? 24'd0 : (DELAY_CYCLES - 24'd1);

   logic [1:0]  state_q, state_d;
   logic [9:0]  save_x_q, save_x_d;
   logic [9:0]  save_y_q, save_y_d;
   logic        has_save_q, has_save_d;
   logic [9:0]  death_count_q, death_count_d;
   logic [23:0] delay_cnt_q, delay_cnt_d;
   logic        restore_valid_q, restore_valid_d;
   logic        frozen_q, frozen_d;
   logic        save_prev_q, save_prev_d;
   logic        death_prev_q, death_prev_d;
   logic        save_rise_s;
   logic        death_rise_s;

   assign save_rise_s  = save_trig & ~save_prev_q;
   assign death_rise_s = death & ~death_prev_q;

   // Next-state logic for the respawn sequencer and the saved position.
   always_comb begin
      state_d         = state_q;
      save_x_d        = save_x_q;
      save_y_d        = save_y_q;
      has_save_d      = has_save_q;
      death_count_d   = death_count_q;
      delay_cnt_d     = delay_cnt_q;
      save_prev_d     = save_trig;
      death_prev_d    = death;

      case (state_q)
         ST_ALIVE: begin
            if (death_rise_s) begin
               state_d = ST_DEAD;
               if (death_count_q != DEATH_MAX) begin
                  death_count_d = death_count_q + 10'd1;
               end else begin
                  death_count_d = death_count_q;
               end
            end else if (respawn_key) begin
               state_d     = ST_DELAY;
               delay_cnt_d = 24'd0;
            end else if (save_rise_s) begin
               save_x_d   = kid_x;
               save_y_d   = kid_y;
               has_save_d = 1'b1;
            end else begin
               state_d = ST_ALIVE;
            end
         end
         ST_DEAD: begin
            if (respawn_key) begin
               state_d     = ST_DELAY;
               delay_cnt_d = 24'd0;
            end else begin
               state_d = ST_DEAD;
            end
         end
         ST_DELAY: begin
            if (delay_cnt_q == DELAY_LAST) begin
               state_d     = ST_RESTORE;
               delay_cnt_d = 24'd0;
            end else begin
               delay_cnt_d = delay_cnt_q + 24'd1;
            end
         end
         ST_RESTORE: begin
            // An ack only counts against a position that is actually on offer.
            if (restore_valid_q && restore_ack) begin
               state_d = ST_ALIVE;
            end else begin
               state_d = ST_RESTORE;
            end
         end
         default: begin
            state_d = ST_ALIVE;
         end
      endcase

      restore_valid_d = (state_d == ST_RESTORE);
      frozen_d        = (state_d != ST_ALIVE);
   end

   // State and output registers; reset drops any save and returns to the spawn point.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= ST_ALIVE;
         save_x_q        <= START_X;
         save_y_q        <= START_Y;
         has_save_q      <= 1'b0;
         death_count_q   <= 10'd0;
         delay_cnt_q     <= 24'd0;
         restore_valid_q <= 1'b0;
         frozen_q        <= 1'b0;
         save_prev_q     <= 1'b0;
         death_prev_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         save_x_q        <= save_x_d;
         save_y_q        <= save_y_d;
         has_save_q      <= has_save_d;
         death_count_q   <= death_count_d;
         delay_cnt_q     <= delay_cnt_d;
         restore_valid_q <= restore_valid_d;
         frozen_q        <= frozen_d;
         save_prev_q     <= save_prev_d;
         death_prev_q    <= death_prev_d;
      end
   end

   assign restore_valid = restore_valid_q;
   assign restore_x     = save_x_q;
   assign restore_y     = save_y_q;
   assign frozen        = frozen_q;
   assign has_save      = has_save_q;
   assign death_count   = death_count_q;

endmodule

// File: tb/tb_save_restore.sv
// Directed bench for save_restore: a per-cycle vector table plus hand sequences
// for the held-valid, voluntary-restart, saturation and async-reset cases.
module tb_save_restore;

   logic       clk;
   logic       rst;
   logic       save_trig;
   logic [9:0] kid_x;
   logic [9:0] kid_y;
   logic       death;
   logic       respawn_key;
   logic       restore_ack;
   logic       restore_valid;
   logic [9:0] restore_x;
   logic [9:0] restore_y;
   logic       frozen;
   logic       has_save;
   logic [9:0] death_count;

   int n_cmp;
   int n_bad;

   save_restore #(
      .START_X     (10'd32),
      .START_Y     (10'd400),
      .DELAY_CYCLES(24'd4),
      .DEATH_MAX   (10'd999)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .save_trig    (save_trig),
      .kid_x        (kid_x),
      .kid_y        (kid_y),
      .death        (death),
      .respawn_key  (respawn_key),
      .restore_ack  (restore_ack),
      .restore_valid(restore_valid),
      .restore_x    (restore_x),
      .restore_y    (restore_y),
      .frozen       (frozen),
      .has_save     (has_save),
      .death_count  (death_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       st;
      logic [9:0] kx;
      logic [9:0] ky;
      logic       d;
      logic       k;
      logic       a;
      logic       ev;
      logic [9:0] ex;
      logic [9:0] ey;
      logic       ef;
      logic       eh;
      logic [9:0] ec;
   } vec_t;

   vec_t vecs [20];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic v, input logic [9:0] x, input logic [9:0] y,
                            input logic f, input logic h, input logic [9:0] c);
      check({tag, ".valid"}, int'(restore_valid), int'(v));
      check({tag, ".x"}, int'(restore_x), int'(x));
      check({tag, ".y"}, int'(restore_y), int'(y));
      check({tag, ".frozen"}, int'(frozen), int'(f));
      check({tag, ".has_save"}, int'(has_save), int'(h));
      check({tag, ".death_count"}, int'(death_count), int'(c));
   endtask

   // Ticks until restore_valid is seen, bounded; returns the number of ticks taken.
   task automatic wait_valid(input string tag, output int cyc);
      cyc = 0;
      while (!restore_valid && cyc < 20) begin
         tick();
         cyc = cyc + 1;
      end
      check({tag, ".valid_seen"}, int'(restore_valid), 1);
   endtask

   task automatic idle_inputs();
      save_trig   = 1'b0;
      death       = 1'b0;
      respawn_key = 1'b0;
      restore_ack = 1'b0;
   endtask

   initial begin
      int cyc;
      n_cmp = 0;
      n_bad = 0;
      idle_inputs();
      kid_x = 10'd0;
      kid_y = 10'd0;
      rst   = 1'b1;

      //            st  kx       ky       d     k     a   | v     x        y        f     h     c
      vecs[0]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 10'd32, 10'd400, 1'b0, 1'b0, 10'd0};
      vecs[1]  = '{1'b0, 10'd0,   10'd0,   1'b1, 1'b0, 1'b0, 1'b0, 10'd32, 10'd400, 1'b1, 1'b0, 10'd1};
      vecs[2]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 10'd32, 10'd400, 1'b1, 1'b0, 10'd1};
      vecs[3]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 10'd32, 10'd400, 1'b1, 1'b0, 10'd1};
      vecs[4]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 10'd32, 10'd400, 1'b1, 1'b0, 10'd1};
      vecs[5]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 10'd32, 10'd400, 1'b1, 1'b0, 10'd1};
      vecs[6]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 10'd32, 10'd400, 1'b1, 1'b0, 10'd1};
      vecs[7]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 1'b1, 10'd32, 10'd400, 1'b1, 1'b0, 10'd1};
      vecs[8]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 10'd32, 10'd400, 1'b0, 1'b0, 10'd1};
      vecs[9]  = '{1'b1, 10'd95,  10'd313, 1'b0, 1'b0, 1'b0, 1'b0, 10'd95, 10'd313, 1'b0, 1'b1, 10'd1};
      vecs[10] = '{1'b1, 10'd500, 10'd600, 1'b0, 1'b0, 1'b0, 1'b0, 10'd95, 10'd313, 1'b0, 1'b1, 10'd1};
      vecs[11] = '{1'b1, 10'd500, 10'd600, 1'b1, 1'b0, 1'b0, 1'b0, 10'd95, 10'd313, 1'b1, 1'b1, 10'd2};
      vecs[12] = '{1'b0, 10'd500, 10'd600, 1'b0, 1'b1, 1'b0, 1'b0, 10'd95, 10'd313, 1'b1, 1'b1, 10'd2};
      vecs[13] = '{1'b0, 10'd500, 10'd600, 1'b0, 1'b0, 1'b1, 1'b0, 10'd95, 10'd313, 1'b1, 1'b1, 10'd2};
      vecs[14] = '{1'b0, 10'd500, 10'd600, 1'b0, 1'b0, 1'b0, 1'b0, 10'd95, 10'd313, 1'b1, 1'b1, 10'd2};
      vecs[15] = '{1'b0, 10'd500, 10'd600, 1'b0, 1'b0, 1'b0, 1'b0, 10'd95, 10'd313, 1'b1, 1'b1, 10'd2};
      vecs[16] = '{1'b0, 10'd500, 10'd600, 1'b0, 1'b0, 1'b0, 1'b1, 10'd95, 10'd313, 1'b1, 1'b1, 10'd2};
      vecs[17] = '{1'b0, 10'd500, 10'd600, 1'b0, 1'b0, 1'b1, 1'b0, 10'd95, 10'd313, 1'b0, 1'b1, 10'd2};
      vecs[18] = '{1'b0, 10'd200, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 10'd95, 10'd313, 1'b0, 1'b1, 10'd2};
      vecs[19] = '{1'b1, 10'd200, 10'd100, 1'b1, 1'b0, 1'b0, 1'b0, 10'd95, 10'd313, 1'b1, 1'b1, 10'd3};

      #3 rst = 1'b0;
      #1 check_all("reset", 1'b0, 10'd32, 10'd400, 1'b0, 1'b0, 10'd0);
      tick();
      rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         save_trig   = vecs[i].st;
         kid_x       = vecs[i].kx;
         kid_y       = vecs[i].ky;
         death       = vecs[i].d;
         respawn_key = vecs[i].k;
         restore_ack = vecs[i].a;
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ex, vecs[i].ey,
                   vecs[i].ef, vecs[i].eh, vecs[i].ec);
      end

      // Held valid without ack: position and valid must stay put.
      idle_inputs();
      respawn_key = 1'b1;
      tick();
      respawn_key = 1'b0;
      wait_valid("hold", cyc);
      check("hold.latency", cyc, 4);
      for (int i = 0; i < 20; i++) begin
         tick();
         check_all("hold.stable", 1'b1, 10'd95, 10'd313, 1'b1, 1'b1, 10'd3);
      end
      restore_ack = 1'b1;
      tick();
      restore_ack = 1'b0;
      check_all("hold.ack", 1'b0, 10'd95, 10'd313, 1'b0, 1'b1, 10'd3);

      // Voluntary restart; key and death during the delay must not disturb it.
      respawn_key = 1'b1;
      tick();
      respawn_key = 1'b0;
      check("vol.frozen", int'(frozen), 1);
      tick();
      respawn_key = 1'b1;
      death       = 1'b1;
      tick();
      respawn_key = 1'b0;
      death       = 1'b0;
      wait_valid("vol", cyc);
      check("vol.latency", cyc, 2);
      check_all("vol.restore", 1'b1, 10'd95, 10'd313, 1'b1, 1'b1, 10'd3);
      restore_ack = 1'b1;
      tick();
      restore_ack = 1'b0;
      check("vol.alive", int'(frozen), 0);

      // 1000 death/respawn rounds: counter saturates at DEATH_MAX.
      for (int i = 0; i < 1000; i++) begin
         death = 1'b1;
         tick();
         death = 1'b0;
         respawn_key = 1'b1;
         tick();
         respawn_key = 1'b0;
         wait_valid("sat", cyc);
         restore_ack = 1'b1;
         tick();
         restore_ack = 1'b0;
         if (i == 994) check("sat.998", int'(death_count), 998);
         if (i == 995) check("sat.999", int'(death_count), 999);
      end
      check("sat.final", int'(death_count), 999);

      // Async reset in the middle of the delay, observed before any clock edge.
      death = 1'b1;
      tick();
      death = 1'b0;
      respawn_key = 1'b1;
      tick();
      respawn_key = 1'b0;
      tick();
      check("pre_rst.frozen", int'(frozen), 1);
      #1 rst = 1'b0;
      #1 check_all("async_rst", 1'b0, 10'd32, 10'd400, 1'b0, 1'b0, 10'd0);

      // Death already high as reset releases counts as a fresh edge.
      death = 1'b1;
      #1 rst = 1'b1;
      tick();
      check_all("rel_death", 1'b0, 10'd32, 10'd400, 1'b1, 1'b0, 10'd1);
      death = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
